// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU data interface.
// Holds access sizes, byte-enable codes, FSM states and the alignment helper.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   // data_be_o is a size/offset code, not a per-lane mask
   localparam logic [3:0] BE_WORD    = 4'b0001;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b0010;
   localparam logic [3:0] BE_BYTE0   = 4'b1000;
   localparam logic [3:0] BE_BYTE1   = 4'b1001;
   localparam logic [3:0] BE_BYTE2   = 4'b1010;
   localparam logic [3:0] BE_BYTE3   = 4'b1100;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT_RV,
      ST_DONE,
      ST_ERR
   } state_e;

   function automatic logic misaligned(
      input logic [1:0] sz,
      input logic [1:0] off
   );
      return ((sz == SZ_HALF) && off[0]) ||
             ((sz == SZ_WORD) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_data_if_if.sv
// Data RAM port bundle: req/gnt/rvalid handshake plus address/data lanes.
// master = LSU side (drives req/add/we/be/wdata), slave = RAM side.
interface lsu_data_if_if;
   logic        data_req_o;
   logic [31:0] data_add_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_wdata_o;
   logic        data_gnt_i;
   logic        data_rvalid_i;
   logic [31:0] data_rdata_i;

   modport master (
      output data_req_o,
      output data_add_o,
      output data_we_o,
      output data_be_o,
      output data_wdata_o,
      input  data_gnt_i,
      input  data_rvalid_i,
      input  data_rdata_i
   );

   modport slave (
      input  data_req_o,
      input  data_add_o,
      input  data_we_o,
      input  data_be_o,
      input  data_wdata_o,
      output data_gnt_i,
      output data_rvalid_i,
      output data_rdata_i
   );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: be code + write-lane placement for the store
// path, lane extraction + sign/zero extension for the load path.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  wr_size_i,
   input  logic [1:0]  wr_off_i,
   input  logic [31:0] wr_data_i,
   output logic [3:0]  wr_be_o,
   output logic [31:0] wr_data_o,
   input  logic [1:0]  rd_size_i,
   input  logic [1:0]  rd_off_i,
   input  logic        rd_uns_i,
   input  logic [31:0] rd_data_i,
   output logic [31:0] rd_data_o
);

   always_comb begin
      wr_be_o   = '0;
      wr_data_o = '0;
      case (wr_size_i)
         SZ_BYTE: begin
            case (wr_off_i)
               2'd0: wr_be_o = BE_BYTE0;
               2'd1: wr_be_o = BE_BYTE1;
               2'd2: wr_be_o = BE_BYTE2;
               default: wr_be_o = BE_BYTE3;
            endcase
            wr_data_o = {24'b0, wr_data_i[7:0]}
                        << {wr_off_i, 3'b000};
         end
         SZ_HALF: begin
            if (wr_off_i[1]) begin
               wr_be_o   = BE_HALF_HI;
               wr_data_o = {wr_data_i[15:0], 16'b0};
            end else begin
               wr_be_o   = BE_HALF_LO;
               wr_data_o = {16'b0, wr_data_i[15:0]};
            end
         end
         SZ_WORD: begin
            wr_be_o   = BE_WORD;
            wr_data_o = wr_data_i;
         end
         default: begin
            wr_be_o   = '0;
            wr_data_o = '0;
         end
      endcase
   end

   logic [31:0] sh;
   logic [15:0] hw;

   always_comb begin
      sh        = rd_data_i >> {rd_off_i, 3'b000};
      hw        = rd_off_i[1] ? rd_data_i[31:16]
                              : rd_data_i[15:0];
      rd_data_o = '0;
      case (rd_size_i)
         SZ_BYTE: begin
            if (rd_uns_i) rd_data_o = {24'b0, sh[7:0]};
            else          rd_data_o = {{24{sh[7]}}, sh[7:0]};
         end
         SZ_HALF: begin
            if (rd_uns_i) rd_data_o = {16'b0, hw};
            else          rd_data_o = {{16{hw[15]}}, hw};
         end
         SZ_WORD: rd_data_o = rd_data_i;
         default: rd_data_o = '0;
      endcase
   end

endmodule

// File: rtl/lsu_data_if.sv
// Load/store stage in front of the data RAM: one access at a time,
// req/gnt/rvalid handshake with timeout, error pulse on bad access.
// Ports: clk, rst_n; core_* access/response; bus = RAM master port.
module lsu_data_if
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter logic [15:0] DMEM_BASE_HI   = 16'h0010
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        core_valid_i,
   output logic        core_ready_o,
   input  logic        core_we_i,
   input  logic [1:0]  core_size_i,
   input  logic        core_unsigned_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wdata_i,
   output logic        core_done_o,
   output logic [31:0] core_rdata_o,
   output logic        core_err_o,
   lsu_data_if_if.master bus
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

   state_e      state_q;
   logic        ready_q;
   logic        done_q;
   logic        err_q;
   logic [31:0] rdata_q;
   logic        req_q;
   logic [31:0] add_q;
   logic        we_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic        st_q;
   logic [1:0]  size_q;
   logic [1:0]  off_q;
   logic        uns_q;

   logic [3:0]  wr_be;
   logic [31:0] wr_data;
   logic [31:0] rd_ext;
   logic        bad_acc;
   logic        tmo;

   lsu_align u_align (
      .wr_size_i (core_size_i),
      .wr_off_i  (core_addr_i[1:0]),
      .wr_data_i (core_wdata_i),
      .wr_be_o   (wr_be),
      .wr_data_o (wr_data),
      .rd_size_i (size_q),
      .rd_off_i  (off_q),
      .rd_uns_i  (uns_q),
      .rd_data_i (bus.data_rdata_i),
      .rd_data_o (rd_ext)
   );

   assign bad_acc = misaligned(core_size_i, core_addr_i[1:0])
                 || (core_size_i == 2'd3)
                 || (core_addr_i[31:16] != DMEM_BASE_HI);
   assign tmo   = (cnt_q == CNT_MAX);
   assign cnt_d = cnt_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         req_q   <= 1'b0;
         add_q   <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         st_q    <= 1'b0;
         size_q  <= '0;
         off_q   <= '0;
         uns_q   <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         unique case (state_q)
            ST_IDLE: begin
               if (core_valid_i && ready_q) begin
                  ready_q <= 1'b0;
                  st_q    <= core_we_i;
                  size_q  <= core_size_i;
                  off_q   <= core_addr_i[1:0];
                  uns_q   <= core_unsigned_i;
                  cnt_q   <= '0;
                  if (bad_acc) begin
                     state_q <= ST_ERR;
                     err_q   <= 1'b1;
                  end else begin
                     state_q <= ST_REQ;
                     req_q   <= 1'b1;
                     add_q   <= {core_addr_i[31:2], 2'b00};
                     we_q    <= core_we_i;
                     be_q    <= wr_be;
                     wdata_q <= core_we_i ? wr_data : '0;
                  end
               end
            end
            ST_REQ: begin
               if (bus.data_gnt_i || tmo) begin
                  req_q   <= 1'b0;
                  add_q   <= '0;
                  we_q    <= 1'b0;
                  be_q    <= '0;
                  wdata_q <= '0;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_d;
               end
               if (bus.data_gnt_i) begin
                  if (st_q) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else if (bus.data_rvalid_i) begin
                     // grant and data in the same cycle
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                     rdata_q <= rd_ext;
                  end else begin
                     state_q <= ST_WAIT_RV;
                  end
               end else if (tmo) begin
                  state_q <= ST_ERR;
                  err_q   <= 1'b1;
               end
            end
            ST_WAIT_RV: begin
               if (bus.data_rvalid_i) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                  rdata_q <= rd_ext;
                  cnt_q   <= '0;
               end else if (tmo) begin
                  state_q <= ST_ERR;
                  err_q   <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_DONE, ST_ERR: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign core_ready_o     = ready_q;
   assign core_done_o      = done_q;
   assign core_err_o       = err_q;
   assign core_rdata_o     = rdata_q;
   assign bus.data_req_o   = req_q;
   assign bus.data_add_o   = add_q;
   assign bus.data_we_o    = we_q;
   assign bus.data_be_o    = be_q;
   assign bus.data_wdata_o = wdata_q;

endmodule

// File: doc/lsu_data_if.md
Name: lsu_data_if

Overview:
- Load/store interface stage that sits directly upstream of the data RAM, between the core's memory-access stage and the RAM's req/gnt/rvalid port.
- Accepts one load or store at a time from the core and generates the size/offset-coded byte-enable and the lane-placed write data.
- Runs the request/grant/valid handshake, with a timeout, and returns sign- or zero-extended load data.
- Flags misaligned accesses and bus timeouts as errors without touching memory.

Parameters:
- TIMEOUT_CYCLES, 16: cycles to wait for data_gnt_i or data_rvalid_i before aborting with an error.
- DMEM_BASE_HI, 16'h0010: upper address half that the data RAM decodes; any other value is an access fault.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- core_valid_i  in  1  core presents an access
- core_ready_o  out  1  LSU idle, can accept an access
- core_we_i  in  1  1 = store, 0 = load
- core_size_i  in  2  0 = byte, 1 = half, 2 = word (3 is illegal)
- core_unsigned_i  in  1  zero-extend load data
- core_addr_i  in  32  byte address
- core_wdata_i  in  32  store data, right-justified
- core_done_o  out  1  one-cycle completion pulse
- core_rdata_o  out  32  extended load data, valid with core_done_o
- core_err_o  out  1  one-cycle error pulse (misalign, fault, timeout)
- data_req_o  out  1  request to the RAM
- data_add_o  out  32  word-aligned address
- data_we_o  out  1  write enable
- data_be_o  out  4  size/offset code
- data_wdata_o  out  32  lane-placed write data
- data_gnt_i  in  1  RAM grant
- data_rvalid_i  in  1  RAM read data valid
- data_rdata_i  in  32  RAM read data, little-endian word

Behaviour:
- Reset: state IDLE, core_ready_o=1, all other outputs 0, timeout counter 0. Reset asserted mid-transaction aborts it silently with no done and no err.
- Accept: an access is captured in IDLE on core_valid_i && core_ready_o. All fields are registered and core_ready_o drops the next cycle.
- Checks, made in the accept cycle:
  - misaligned: half with addr[0]=1, or word with addr[1:0]!=0
  - illegal: size==3
  - fault: addr[31:16]!=DMEM_BASE_HI
  - Any of these goes to ERR and never raises data_req_o.
- data_be_o encoding:
  - word: 4'b0001
  - half at offset 0: 4'b0011; half at offset 2: 4'b0010
  - byte at offset 0/1/2/3: 4'b1000 / 4'b1001 / 4'b1010 / 4'b1100
- data_wdata_o lane placement:
  - byte at offset k goes to bits [8k+7:8k]
  - half at offset 2 goes to [31:16]; half at offset 0 goes to [15:0]
  - word passes through unchanged
  - Unused lanes are 0.
- data_add_o = {addr[31:2], 2'b00}.
- FSM: IDLE -> REQ -> (store: DONE | load: WAIT_RV -> DONE); any state -> ERR on timeout; DONE/ERR -> IDLE after one cycle.
- REQ: data_req_o=1, and address, we, be and wdata are held stable until the cycle data_gnt_i=1 is sampled. That cycle drops data_req_o the next cycle and clears the counter.
- Store completion: a store completes on grant and enters DONE.
- Load completion: a load enters WAIT_RV and latches data_rdata_i on the first data_rvalid_i=1. Extraction:
  - byte k: bits [8k+7:8k]
  - half: [31:16] if offset 2, else [15:0]
  - word: full 32 bits
  - Then sign-extend unless core_unsigned_i was set.
- Simultaneous events: data_gnt_i and data_rvalid_i both high in the same REQ cycle for a load goes straight to DONE, using that cycle's data.
- Timeout: the counter increments each cycle in REQ and WAIT_RV. Reaching TIMEOUT_CYCLES-1 without the awaited event goes to ERR.
- DONE: core_done_o=1 for one cycle, with core_rdata_o valid (0 for stores). ERR: core_err_o=1 for one cycle, core_rdata_o=0.
- core_ready_o returns to 1 in the cycle after DONE/ERR. Back-to-back accesses therefore take at least 3 cycles (store) or 4 cycles (load).
- data_rvalid_i or data_gnt_i arriving while IDLE is ignored.

Decomposition:
- Shared package lsu_pkg holds:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD)
  - be code constants (BE_WORD, BE_HALF_LO, BE_HALF_HI, BE_BYTE0..BE_BYTE3)
  - FSM state enum
- Sub-module lsu_align: combinational be/wdata generation plus read-data extraction/extension. Shared by the write path and the read path.

Test Plan:
- Word store 0x00100010 = 0xDEADBEEF, gnt after 2 cycles -> be=0001, wdata=0xDEADBEEF, add=0x00100010, done pulse, rdata=0.
- Signed byte load at 0x00100013, rdata_i=0x80112233 -> be=1100, core_rdata_o=0xFFFFFF80. Same access with unsigned=1 -> 0x00000080.
- Half store at 0x00100006 = 0x0000A5A5 -> be=0010, wdata=0xA5A50000. Half at offset 1 -> err pulse, no data_req_o.
- Access to 0x00200000 -> err pulse, data_req_o never asserted. Load with gnt but no rvalid for TIMEOUT_CYCLES -> err, FSM back to IDLE.
- Load where gnt and rvalid arrive together with rdata=0x12345678 -> done with 0x12345678 in the next cycle.
- rst_n asserted during WAIT_RV -> all outputs 0 immediately, no done/err, next access proceeds normally.
